pc_unit: RTL and testbench

Parametrised program-counter unit for the AK-16 fetch stage: holds the current PC, selects the next PC from sequential, call, return, branch and exception sources with fixed priority, and keeps a small circular return-address stack (RAS) to predict return targets. The unit supports fetch stalls without losing redirects, and reports RAS overflow and underflow. It sits at the head of `if_stage` and drives the instruction-memory address.

---
 rtl/ak16_pkg.sv | 17 +
 rtl/ras_stack.sv | 55 +++++
 rtl/pc_unit.sv | 120 ++++++++++++
 tb/tb_pc_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ak16_pkg.sv
// Shared AK-16 fetch-stage types: PC source encoding and default vectors.
package ak16_pkg;

    typedef enum logic [2:0] {
        SEQ      = 3'd0,
        CALL     = 3'd1,
        RET      = 3'd2,
        RET_MISS = 3'd3,
        BR       = 3'd4,
        EXC      = 3'd5,
        RST      = 3'd6
    } pc_src_e;

    localparam int unsigned RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned EXC_VEC_DEFAULT  = 32'h0000_0002;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored. Entry contents are deliberately left unreset.
module ras_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_reg [DEPTH];
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_inc;
    logic [CNT_W-1:0] count_reg;

    assign ptr_inc = ptr_reg + PTR_W'(1);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign top     = mem_reg[ptr_reg];
    assign count   = count_reg;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push) begin
            mem_reg[ptr_inc] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_inc;
            if (!full) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_reg   <= ptr_reg - PTR_W'(1);
            count_reg <= count_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// AK-16 program counter: fixed-priority next-PC mux (exc > br > ret > call > seq),
// PC register, and return-address prediction with overflow/underflow pulses.
module pc_unit
    import ak16_pkg::*;
#(
    parameter int          PC_W      = 16,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned EXC_VEC   = EXC_VEC_DEFAULT,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pc_en,
    input  logic                         exc_valid,
    input  logic                         br_taken,
    input  logic [PC_W-1:0]              br_target,
    input  logic                         call,
    input  logic [PC_W-1:0]              call_target,
    input  logic                         ret,
    input  logic [PC_W-1:0]              ret_target,
    output logic [PC_W-1:0]              pc_cur,
    output logic [PC_W-1:0]              pc_next,
    output pc_src_e                      pc_src,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] EXC_VEC_W  = PC_W'(EXC_VEC);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_seq;
    pc_src_e         src_reg;
    pc_src_e         src_next;
    logic            ovf_reg, ovf_next;
    logic            unf_reg, unf_next;
    logic            ras_push, ras_pop, ras_clear;
    logic [PC_W-1:0] ras_top;
    logic            ras_full, ras_empty;

    assign pc_seq = pc_reg + PC_W'(STEP);

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (pc_seq),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Redirects bypass pc_en so a stalled fetch never drops them.
    always_comb begin
        pc_next   = pc_reg;
        src_next  = src_reg;
        ovf_next  = 1'b0;
        unf_next  = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        if (rst) begin
            pc_next  = RESET_PC_W;
            src_next = RST;
        end else if (exc_valid) begin
            pc_next   = EXC_VEC_W;
            src_next  = EXC;
            ras_clear = 1'b1;
        end else if (br_taken) begin
            pc_next  = br_target;
            src_next = BR;
        end else if (pc_en && ret) begin
            if (ras_empty) begin
                pc_next  = ret_target;
                src_next = RET_MISS;
                unf_next = 1'b1;
            end else begin
                pc_next  = ras_top;
                src_next = RET;
                ras_pop  = 1'b1;
            end
        end else if (pc_en && call) begin
            pc_next  = call_target;
            src_next = CALL;
            ras_push = 1'b1;
            ovf_next = ras_full;
        end else if (pc_en) begin
            pc_next  = pc_seq;
            src_next = SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg  <= RESET_PC_W;
            src_reg <= RST;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            src_reg <= src_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    assign pc_cur        = pc_reg;
    assign pc_src        = src_reg;
    assign ras_overflow  = ovf_reg;
    assign ras_underflow = unf_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model checked every cycle,
// plus literal expectations taken straight from the intended behaviour.
module tb_pc_unit;
    import ak16_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_en = 1'b0;
    logic        exc_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = '0;
    logic        call = 1'b0;
    logic [15:0] call_target = '0;
    logic        ret = 1'b0;
    logic [15:0] ret_target = '0;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    pc_src_e     pc_src;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    pc_unit #(
        .PC_W      (16),
        .STEP      (1),
        .RESET_PC  (0),
        .EXC_VEC   (16'h0002),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_en         (pc_en),
        .exc_valid     (exc_valid),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .call          (call),
        .call_target   (call_target),
        .ret           (ret),
        .ret_target    (ret_target),
        .pc_cur        (pc_cur),
        .pc_next       (pc_next),
        .pc_src        (pc_src),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: PC, source code (0..6), RAS as a bounded queue.
    logic [15:0] m_pc;
    int          m_src;
    logic        m_ovf, m_unf;
    logic [15:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_next();
        if (rst)                   return 16'h0000;
        else if (exc_valid)        return 16'h0002;
        else if (br_taken)         return br_target;
        else if (pc_en && ret)     return (m_ras.size() > 0) ? m_ras[$] : ret_target;
        else if (pc_en && call)    return call_target;
        else if (pc_en)            return m_pc + 16'd1;
        else                       return m_pc;
    endfunction

    task automatic model_update();
        logic [15:0] nxt;
        nxt = exp_next();
        if (rst) begin
            m_pc  = 16'h0000;
            m_src = 6;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_ras.delete();
        end else begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
            if (exc_valid) begin
                m_ras.delete();
                m_src = 5;
            end else if (br_taken) begin
                m_src = 4;
            end else if (pc_en && ret) begin
                if (m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                    m_src = 2;
                end else begin
                    m_unf = 1'b1;
                    m_src = 3;
                end
            end else if (pc_en && call) begin
                m_ras.push_back(m_pc + 16'd1);
                if (m_ras.size() > 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_src = 1;
            end else if (pc_en) begin
                m_src = 0;
            end
            m_pc = nxt;
        end
    endtask

    // Inputs change on the falling edge; compare shortly after, mid-cycle.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("pc_cur",        pc_cur,        m_pc);
            chk("pc_src",        pc_src,        m_src);
            chk("ras_count",     ras_count,     m_ras.size());
            chk("ras_overflow",  ras_overflow,  m_ovf);
            chk("ras_underflow", ras_underflow, m_unf);
            chk("pc_next",       pc_next,       exp_next());
        end
    end

    task automatic cyc(input logic r, input logic en, input logic e, input logic b,
                       input logic [15:0] bt, input logic c, input logic [15:0] ct,
                       input logic rv, input logic [15:0] rt);
        @(negedge clk);
        rst = r; pc_en = en; exc_valid = e; br_taken = b; br_target = bt;
        call = c; call_target = ct; ret = rv; ret_target = rt;
        @(posedge clk);
        #1;
        model_update();
        if (r) chk_en = 1'b1;
        $display("cyc rst=%b en=%b exc=%b br=%b call=%b ret=%b -> pc_cur=%h src=%0d cnt=%0d ovf=%b unf=%b",
                 r, en, e, b, c, rv, pc_cur, pc_src, ras_count, ras_overflow, ras_underflow);
    endtask

    task automatic seq_n(input int n);
        repeat (n) cyc(0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    endtask
    task automatic stall_n(input int n);
        repeat (n) cyc(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    endtask
    task automatic do_br(input logic [15:0] t, input logic en);
        cyc(0, en, 0, 1, t, 0, 16'h0, 0, 16'h0);
    endtask
    task automatic do_call(input logic [15:0] t);
        cyc(0, 1, 0, 0, 16'h0, 1, t, 0, 16'h0);
    endtask
    task automatic do_ret(input logic [15:0] rt);
        cyc(0, 1, 0, 0, 16'h0, 0, 16'h0, 1, rt);
    endtask

    initial begin
        // Reset and sequential wrap
        cyc(1, 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        cyc(1, 1, 1, 1, 16'h1234, 1, 16'h0, 0, 16'h0);
        chk("lit_reset_pc", pc_cur, 16'h0000);
        chk("lit_reset_src", pc_src, 6);
        chk("lit_reset_cnt", ras_count, 0);
        seq_n(3);
        chk("lit_seq_pc3", pc_cur, 16'h0003);
        do_br(16'hFFFF, 1);
        seq_n(1);
        chk("lit_wrap_pc", pc_cur, 16'h0000);

        // Stall with redirect
        do_br(16'h0005, 1);
        stall_n(4);
        chk("lit_stall_pc", pc_cur, 16'h0005);
        do_br(16'h0040, 0);
        chk("lit_stall_br_pc", pc_cur, 16'h0040);
        chk("lit_stall_br_src", pc_src, 4);

        // Call/return nesting
        do_br(16'd10, 1);  do_call(16'd100);
        do_br(16'd20, 1);  do_call(16'd200);
        do_br(16'd30, 1);  do_call(16'd300);
        chk("lit_nest_cnt", ras_count, 3);
        do_ret(16'h0);  chk("lit_ret1", pc_cur, 16'd31);
        do_ret(16'h0);  chk("lit_ret2", pc_cur, 16'd21);
        do_ret(16'h0);  chk("lit_ret3", pc_cur, 16'd11);
        chk("lit_nest_cnt0", ras_count, 0);

        // Overflow then underflow
        do_br(16'h0010, 1);
        do_call(16'h0100); do_call(16'h0200); do_call(16'h0300); do_call(16'h0400);
        chk("lit_no_ovf", ras_overflow, 1'b0);
        do_call(16'h0500);
        chk("lit_ovf", ras_overflow, 1'b1);
        chk("lit_ovf_cnt", ras_count, 4);
        do_ret(16'h0);  chk("lit_oret1", pc_cur, 16'h0401);
        chk("lit_ovf_once", ras_overflow, 1'b0);
        do_ret(16'h0);  chk("lit_oret2", pc_cur, 16'h0301);
        do_ret(16'h0);  chk("lit_oret3", pc_cur, 16'h0201);
        do_ret(16'h0);  chk("lit_oret4", pc_cur, 16'h0101);
        do_ret(16'h0077);
        chk("lit_unf_pc", pc_cur, 16'h0077);
        chk("lit_unf", ras_underflow, 1'b1);
        chk("lit_unf_src", pc_src, 3);
        do_ret(16'h0055);
        chk("lit_unf_b2b", ras_underflow, 1'b1);

        // Simultaneous events
        do_call(16'h0600); do_call(16'h0700);
        cyc(0, 1, 1, 1, 16'h0900, 1, 16'h0800, 0, 16'h0);
        chk("lit_exc_pc", pc_cur, 16'h0002);
        chk("lit_exc_cnt", ras_count, 0);
        do_call(16'h0A00); do_call(16'h0B00);
        cyc(0, 1, 0, 0, 16'h0, 1, 16'h0C00, 1, 16'h0099);
        chk("lit_callret_pc", pc_cur, 16'h0A01);
        chk("lit_callret_cnt", ras_count, 1);
        stall_n(2);
        cyc(0, 0, 0, 0, 16'h0, 1, 16'h0D00, 1, 16'h0);
        chk("lit_stall_hold", pc_cur, 16'h0A01);

        // Reset mid-operation
        do_call(16'h0D00); do_call(16'h0E00);
        chk("lit_pre_rst_cnt", ras_count, 3);
        cyc(1, 0, 0, 1, 16'h1234, 0, 16'h0, 0, 16'h0);
        chk("lit_mid_rst_pc", pc_cur, 16'h0000);
        chk("lit_mid_rst_cnt", ras_count, 0);
        chk("lit_mid_rst_src", pc_src, 6);
        chk("lit_mid_rst_pulse", {ras_overflow, ras_underflow}, 2'b00);
        seq_n(2);

        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
